// File: rtl/fsm2_seq_checker.sv
// Receive-side checker for the 3-bit FSM2 sequence generator: verifies each sample follows the last.
// Latency: every output is registered at the sampling edge, so a response shows one cycle after its sample.
// Backpressure: none; en=0 freezes all state and forces err_pulse low.
//
// Ports:
//   clk                      rising-edge clock
//   clr                      synchronous active-high reset
//   en                       sample enable (0 = hold state)
//   Q2,Q1,Q0                 generator output bits, sampled as {Q2,Q1,Q0}
//   locked                   checker is in LOCKED
//   err_pulse                one-cycle flag for a mismatch seen while LOCKED
//   err_cnt[ERR_CNT_W-1:0]   saturating count of LOCKED mismatches (cleared only by clr)
//   exp_q[2:0]               expected next sample
//   err_sticky               only when FSM2_CHK_STICKY_EN is defined; set on the first error, held until clr
//
// Optional feature macro: FSM2_CHK_STICKY_EN

module fsm2_seq_checker #(
    parameter int SEQ_MODE  = 0,   // 0 = binary up-count, 1 = 3-bit Gray
    parameter int LOCK_CNT  = 4,   // consecutive matches to lock (1..15)
    parameter int LOSS_CNT  = 2,   // consecutive LOCKED mismatches to unlock (0 = never)
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 Q0,
    input  logic                 Q1,
    input  logic                 Q2,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [2:0]           exp_q
`ifdef FSM2_CHK_STICKY_EN
    ,
    output logic                 err_sticky
`endif
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] LP_LOCK = 4'(LOCK_CNT);
    localparam logic [3:0] LP_LOSS = 4'(LOSS_CNT);

    // Successor of a sample in the configured sequence.
    function automatic logic [2:0] f_nxt(input logic [2:0] x);
        logic [2:0] y;
        y = x + 3'd1;
        if (SEQ_MODE == 1) begin
            case (x)
                3'd0:    y = 3'd1;
                3'd1:    y = 3'd3;
                3'd3:    y = 3'd2;
                3'd2:    y = 3'd6;
                3'd6:    y = 3'd7;
                3'd7:    y = 3'd5;
                3'd5:    y = 3'd4;
                default: y = 3'd0;  // 4 wraps to 0
            endcase
        end
        return y;
    endfunction

    state_t                 r_state;
    logic [2:0]             r_prev;
    logic                   r_prev_valid;
    logic [3:0]             r_match_run;
    logic [3:0]             r_miss_run;
    logic                   r_locked;
    logic                   r_err_pulse;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic [2:0]             r_exp_q;
`ifdef FSM2_CHK_STICKY_EN
    logic                   r_err_sticky;
`endif

    logic [2:0]             w_cur;
    logic                   w_match;
    logic [3:0]             w_match_inc;
    logic [3:0]             w_miss_inc;
    logic [ERR_CNT_W-1:0]   w_cnt_max;

    assign w_cur       = {Q2, Q1, Q0};
    assign w_match     = r_prev_valid && (w_cur == f_nxt(r_prev));
    assign w_match_inc = r_match_run + 4'd1;
    // Saturate the miss run so it cannot wrap when lock loss is disabled.
    assign w_miss_inc  = (r_miss_run == 4'hF) ? 4'hF : (r_miss_run + 4'd1);
    assign w_cnt_max   = '1;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= ST_HUNT;
            r_prev       <= 3'b000;
            r_prev_valid <= 1'b0;
            r_match_run  <= 4'd0;
            r_miss_run   <= 4'd0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_cnt    <= '0;
            r_exp_q      <= 3'b000;
`ifdef FSM2_CHK_STICKY_EN
            r_err_sticky <= 1'b0;
`endif
        end else if (!en) begin
            r_err_pulse <= 1'b0;
        end else begin
            // Always resync to the actual sample, matched or not.
            r_prev       <= w_cur;
            r_prev_valid <= 1'b1;
            r_exp_q      <= f_nxt(w_cur);
            r_err_pulse  <= 1'b0;

            case (r_state)
                ST_HUNT: begin
                    if (w_match) begin
                        if (w_match_inc == LP_LOCK) begin
                            r_state     <= ST_LOCKED;
                            r_locked    <= 1'b1;
                            r_match_run <= 4'd0;
                            r_miss_run  <= 4'd0;
                        end else begin
                            r_match_run <= w_match_inc;
                        end
                    end else begin
                        // Covers both a wrong sample and the first sample after reset.
                        r_match_run <= 4'd0;
                    end
                end

                ST_LOCKED: begin
                    if (w_match) begin
                        r_miss_run <= 4'd0;
                    end else begin
                        r_err_pulse <= 1'b1;
                        if (r_err_cnt != w_cnt_max) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
`ifdef FSM2_CHK_STICKY_EN
                        r_err_sticky <= 1'b1;
`endif
                        if ((LOSS_CNT != 0) && (w_miss_inc == LP_LOSS)) begin
                            r_state     <= ST_HUNT;
                            r_locked    <= 1'b0;
                            r_miss_run  <= 4'd0;
                            r_match_run <= 4'd0;
                        end else begin
                            r_miss_run <= w_miss_inc;
                        end
                    end
                end
            endcase
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign exp_q     = r_exp_q;
`ifdef FSM2_CHK_STICKY_EN
    assign err_sticky = r_err_sticky;
`endif

endmodule
